seq_shift_right: RTL

- Multi-cycle right shifter for the processor's shift datapath; the right-direction counterpart of the left-shift stage chain used by the ALU.
- Performs logical (SRL) or arithmetic (SRA) right shift of a 32-bit operand by a 5-bit amount.
- Applies one binary-weighted stage per cycle (16, 8, 4, 2, 1) under a start/ready handshake.
- Lets the ALU off-load long right shifts without a wide single-cycle barrel.

---
 rtl/seq_shift_right_pkg.sv | 16 +
 rtl/seq_shift_right_sr_stage.sv | 13 +
 rtl/seq_shift_right.sv | 109 ++++++++++
 3 files changed

// File: rtl/seq_shift_right_pkg.sv
// Shared constants and state encoding for the multi-cycle right shifter.
package seq_shift_right_pkg;

   localparam int unsigned SrWidth  = 32;
   localparam int unsigned SrShamtW = 5;

   // First stage applied is the 16-bit one; step counts down to 0.
   localparam logic [2:0] StepInit = 3'd4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_shift_right_sr_stage.sv
// One constant-distance right-shift stage with an external fill bit.
module seq_shift_right_sr_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   assign data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle SRL/SRA: one binary-weighted stage (16, 8, 4, 2, 1) per cycle under start/ready.
module seq_shift_right
   import seq_shift_right_pkg::*;
#(
   parameter int unsigned WIDTH   = SrWidth,
   parameter int unsigned SHAMT_W = SrShamtW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_start,
   input  logic [WIDTH-1:0]   data_operand,
   input  logic [SHAMT_W-1:0] ctrl_shamt,
   input  logic               ctrl_arith,
   output logic               ctrl_busy,
   output logic               data_resultRDY,
   output logic [WIDTH-1:0]   data_result
);

   state_e             state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic               arith_q, arith_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [WIDTH-1:0]   stage_out [SHAMT_W];
   logic [WIDTH-1:0]   shifted;
   logic               fill;

   // Fill comes from the latched operand sign, never from the working register.
   assign fill = arith_q & sign_q;

   for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
      seq_shift_right_sr_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << g)
      ) u_stage (
         .data_i (work_q),
         .fill_i (fill),
         .data_o (stage_out[g])
      );
   end

   assign shifted = shamt_q[step_q] ? stage_out[step_q] : work_q;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      work_d   = work_q;
      shamt_d  = shamt_q;
      arith_d  = arith_q;
      sign_d   = sign_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl_start) begin
               work_d  = data_operand;
               shamt_d = ctrl_shamt;
               arith_d = ctrl_arith;
               sign_d  = data_operand[WIDTH-1];
               step_d  = StepInit;
               state_d = StShift;
            end
         end
         StShift: begin
            work_d = shifted;
            if (step_q == 3'd0) begin
               step_d   = StepInit;
               result_d = shifted;
               state_d  = StDone;
            end else begin
               step_d = step_q - 3'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         step_q   <= StepInit;
         work_q   <= '0;
         shamt_q  <= '0;
         arith_q  <= 1'b0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         work_q   <= work_d;
         shamt_q  <= shamt_d;
         arith_q  <= arith_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

   assign ctrl_busy      = (state_q != StIdle);
   assign data_resultRDY = (state_q == StDone);
   assign data_result    = result_q;

endmodule
